// File: rtl/des_decryption_iterative.sv
// Iterative DES core: one Feistel round per clock, 16 rounds per block, keys applied K16..K1.
// Optional `DES_DEC_ENCRYPT_MODE_EN adds an `encrypt` input that selects forward key order.
module des_decryption_iterative (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
`ifdef DES_DEC_ENCRYPT_MODE_EN
  input  logic         encrypt,
`endif
  input  logic [63:0]  ciphertext,
  input  logic [767:0] round_keys,
  output logic         busy,
  output logic         output_valid,
  output logic [63:0]  result
);

  // DES bit n (1 = MSB) of a w-bit vector lives at index w-n throughout this file.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FINAL = 2'd2
  } state_t;

  // Each entry holds rows 0..3 of one S-box, 16 nibbles per row, entry 0 in the top nibble.
  localparam logic [255:0] SBOX [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  function automatic logic [63:0] ip_perm(input logic [63:0] d);
    return {d[6],  d[14], d[22], d[30], d[38], d[46], d[54], d[62],
            d[4],  d[12], d[20], d[28], d[36], d[44], d[52], d[60],
            d[2],  d[10], d[18], d[26], d[34], d[42], d[50], d[58],
            d[0],  d[8],  d[16], d[24], d[32], d[40], d[48], d[56],
            d[7],  d[15], d[23], d[31], d[39], d[47], d[55], d[63],
            d[5],  d[13], d[21], d[29], d[37], d[45], d[53], d[61],
            d[3],  d[11], d[19], d[27], d[35], d[43], d[51], d[59],
            d[1],  d[9],  d[17], d[25], d[33], d[41], d[49], d[57]};
  endfunction

  function automatic logic [63:0] fp_perm(input logic [63:0] d);
    return {d[24], d[56], d[16], d[48], d[8],  d[40], d[0],  d[32],
            d[25], d[57], d[17], d[49], d[9],  d[41], d[1],  d[33],
            d[26], d[58], d[18], d[50], d[10], d[42], d[2],  d[34],
            d[27], d[59], d[19], d[51], d[11], d[43], d[3],  d[35],
            d[28], d[60], d[20], d[52], d[12], d[44], d[4],  d[36],
            d[29], d[61], d[21], d[53], d[13], d[45], d[5],  d[37],
            d[30], d[62], d[22], d[54], d[14], d[46], d[6],  d[38],
            d[31], d[63], d[23], d[55], d[15], d[47], d[7],  d[39]};
  endfunction

  function automatic logic [47:0] expand(input logic [31:0] r);
    return {r[0],  r[31], r[30], r[29], r[28], r[27],
            r[28], r[27], r[26], r[25], r[24], r[23],
            r[24], r[23], r[22], r[21], r[20], r[19],
            r[20], r[19], r[18], r[17], r[16], r[15],
            r[16], r[15], r[14], r[13], r[12], r[11],
            r[12], r[11], r[10], r[9],  r[8],  r[7],
            r[8],  r[7],  r[6],  r[5],  r[4],  r[3],
            r[4],  r[3],  r[2],  r[1],  r[0],  r[31]};
  endfunction

  function automatic logic [31:0] p_perm(input logic [31:0] s);
    return {s[16], s[25], s[12], s[11], s[3],  s[20], s[4],  s[15],
            s[31], s[17], s[9],  s[6],  s[27], s[14], s[1],  s[22],
            s[30], s[24], s[8],  s[18], s[0],  s[5],  s[29], s[23],
            s[13], s[19], s[2],  s[26], s[10], s[21], s[28], s[7]};
  endfunction

  // Entry e of an S-box sits at bits [255-4e -: 4]; 255-4e is {~e, 2'b11} for a 6-bit e.
  function automatic logic [31:0] f_round(input logic [31:0] r, input logic [47:0] k);
    logic [47:0]  x;
    logic [5:0]   six;
    logic [5:0]   entry;
    logic [255:0] sb;
    logic [31:0]  s;
    x = expand(r) ^ k;
    s = 32'h0;
    for (int i = 0; i < 8; i++) begin
      six   = x[47-6*i -: 6];
      entry = {six[5], six[0], six[4:1]};
      sb    = SBOX[i];
      s[31-4*i -: 4] = sb[{~entry, 2'b11} -: 4];
    end
    return p_perm(s);
  endfunction

  state_t        state_r;
  state_t        state_nx_s;
  logic [31:0]   l_r;
  logic [31:0]   r_r;
  logic [47:0]   key_r [16];
  logic [3:0]    round_cnt_r;
  logic [3:0]    key_idx_s;
  logic [47:0]   round_key_s;
  logic [31:0]   f_out_s;
  logic          busy_r;
  logic          valid_r;
  logic [63:0]   result_r;
`ifdef DES_DEC_ENCRYPT_MODE_EN
  logic          enc_r;
`endif

  assign busy         = busy_r;
  assign output_valid = valid_r;
  assign result       = result_r;

  // Round-key selection (K16 first when decrypting) and the round function.
  always_comb begin
    key_idx_s = 4'd15 - round_cnt_r;
`ifdef DES_DEC_ENCRYPT_MODE_EN
    if (enc_r) begin
      key_idx_s = round_cnt_r;
    end else begin
      key_idx_s = 4'd15 - round_cnt_r;
    end
`endif
    round_key_s = key_r[key_idx_s];
    f_out_s     = f_round(r_r, round_key_s);
  end

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_nx_s = S_RUN;
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_RUN: begin
        if (round_cnt_r == 4'd15) begin
          state_nx_s = S_FINAL;
        end else begin
          state_nx_s = S_RUN;
        end
      end
      S_FINAL: state_nx_s = S_IDLE;
      default: state_nx_s = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Block datapath, key latch and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      l_r         <= 32'h0;
      r_r         <= 32'h0;
      round_cnt_r <= 4'd0;
      busy_r      <= 1'b0;
      valid_r     <= 1'b0;
      result_r    <= 64'h0;
      for (int i = 0; i < 16; i++) begin
        key_r[i] <= 48'h0;
      end
`ifdef DES_DEC_ENCRYPT_MODE_EN
      enc_r       <= 1'b0;
`endif
    end else begin
      valid_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start) begin
            {l_r, r_r}  <= ip_perm(ciphertext);
            round_cnt_r <= 4'd0;
            busy_r      <= 1'b1;
            for (int i = 0; i < 16; i++) begin
              key_r[i] <= round_keys[767-48*i -: 48];
            end
`ifdef DES_DEC_ENCRYPT_MODE_EN
            enc_r       <= encrypt;
`endif
          end
        end
        S_RUN: begin
          l_r <= r_r;
          r_r <= l_r ^ f_out_s;
          // Counter parks at 15 on the last round rather than wrapping.
          if (round_cnt_r != 4'd15) begin
            round_cnt_r <= round_cnt_r + 4'd1;
          end
        end
        S_FINAL: begin
          result_r <= fp_perm({r_r, l_r});
          valid_r  <= 1'b1;
          busy_r   <= 1'b0;
        end
        default: busy_r <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_des_decryption_iterative.sv
// Self-checking bench for des_decryption_iterative against a table-driven DES model
// (key schedule included); the encrypt-mode scenario runs when DES_DEC_ENCRYPT_MODE_EN is defined.
module tb_des_decryption_iterative;

  logic         clk;
  logic         rst;
  logic         start;
  logic [63:0]  ciphertext;
  logic [767:0] round_keys;
  logic         busy;
  logic         output_valid;
  logic [63:0]  result;
`ifdef DES_DEC_ENCRYPT_MODE_EN
  logic         encrypt;
`endif

  int checks;
  int errors;

  localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
  localparam logic [63:0] PT_A  = 64'h0123456789ABCDEF;
  localparam logic [63:0] CT_A  = 64'h85E813540F0AB405;
  localparam logic [63:0] CT_Z  = 64'h8CA64DE9C1B123A7;

  des_decryption_iterative dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
`ifdef DES_DEC_ENCRYPT_MODE_EN
    .encrypt      (encrypt),
`endif
    .ciphertext   (ciphertext),
    .round_keys   (round_keys),
    .busy         (busy),
    .output_valid (output_valid),
    .result       (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Standard DES tables, bit 1 = MSB.
  localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                               62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                               57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                               61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                               38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                               36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                               34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
  localparam int E_T [48]  = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                               16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  localparam int P_T [32]  = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                               2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
  localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
                                19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                                41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  localparam int SH_T [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  localparam int SB [512] = '{
    14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,  0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
    4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,  15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
    15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,  3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
    0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,  13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
    10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,  13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
    13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,  1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
    7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,  13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
    10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,  3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
    2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,  14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
    4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,  11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
    12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,  10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
    9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,  4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
    4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,  13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
    1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,  6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
    13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,  1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
    7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,  2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

  function automatic logic [63:0] ip_m(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
    return y;
  endfunction

  function automatic logic [63:0] fp_m(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
    return y;
  endfunction

  function automatic logic [31:0] f_m(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] e;
    logic [31:0] s;
    logic [31:0] p;
    logic [5:0]  six;
    int          row;
    int          col;
    for (int i = 0; i < 48; i++) e[47-i] = r[32-E_T[i]];
    e = e ^ k;
    s = 32'h0;
    for (int b = 0; b < 8; b++) begin
      six = e[47-6*b -: 6];
      row = int'({six[5], six[0]});
      col = int'(six[4:1]);
      s   = {s[27:0], 4'(SB[b*64 + row*16 + col])};
    end
    for (int i = 0; i < 32; i++) p[31-i] = s[32-P_T[i]];
    return p;
  endfunction

  function automatic logic [767:0] key_sched(input logic [63:0] key);
    logic [55:0]  cd;
    logic [27:0]  c;
    logic [27:0]  d;
    logic [55:0]  joined;
    logic [47:0]  k;
    logic [767:0] ks;
    for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1_T[i]];
    c = cd[55:28];
    d = cd[27:0];
    for (int r = 0; r < 16; r++) begin
      for (int s = 0; s < SH_T[r]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      joined = {c, d};
      for (int i = 0; i < 48; i++) k[47-i] = joined[56-PC2_T[i]];
      ks[767-48*r -: 48] = k;
    end
    return ks;
  endfunction

  function automatic logic [63:0] des_model(input logic [63:0] blk, input logic [767:0] ks, input bit enc);
    logic [63:0] lr;
    logic [31:0] l;
    logic [31:0] r;
    logic [31:0] t;
    int          kn;
    lr = ip_m(blk);
    l  = lr[63:32];
    r  = lr[31:0];
    for (int i = 0; i < 16; i++) begin
      kn = enc ? i : 15 - i;
      t  = r;
      r  = l ^ f_m(r, ks[767-48*kn -: 48]);
      l  = t;
    end
    return fp_m({r, l});
  endfunction

  function automatic logic [767:0] rand_keys();
    logic [767:0] v;
    for (int i = 0; i < 24; i++) v[32*i +: 32] = $urandom();
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [63:0] ct, input logic [767:0] ks);
    ciphertext = ct;
    round_keys = ks;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  // Watches a bounded number of edges; first_ov = -1 means no pulse was seen.
  task automatic watch(input int n_edges, output int first_ov, output int n_ov, output logic [63:0] res);
    first_ov = -1;
    n_ov     = 0;
    res      = 64'h0;
    for (int j = 1; j <= n_edges; j++) begin
      tick();
      if (output_valid === 1'b1) begin
        n_ov++;
        if (first_ov < 0) begin
          first_ov = j;
          res      = result;
        end
      end
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({busy, output_valid} !== 2'b00) begin
      errors++;
      $display("FAIL reset_flags: busy/valid=%b expected 00", {busy, output_valid});
    end
    checks++;
    if (result !== 64'h0) begin
      errors++;
      $display("FAIL reset_result: got %h expected 0", result);
    end
  endtask

  task automatic test_known_vector();
    logic [1:0] exp_flags;
    do_start(CT_A, key_sched(KEY_A));
    checks++;
    if ({busy, output_valid} !== 2'b10) begin
      errors++;
      $display("FAIL kv_flags_e0: busy/valid=%b expected 10", {busy, output_valid});
    end
    for (int j = 1; j <= 17; j++) begin
      tick();
      exp_flags = {(j <= 16), (j == 17)};
      checks++;
      if ({busy, output_valid} !== exp_flags) begin
        errors++;
        $display("FAIL kv_flags_e%0d: busy/valid=%b expected %b", j, {busy, output_valid}, exp_flags);
      end
    end
    checks++;
    if (result !== PT_A) begin
      errors++;
      $display("FAIL kv_result: got %h expected %h", result, PT_A);
    end
    tick();
    checks++;
    if (output_valid !== 1'b0 || result !== PT_A) begin
      errors++;
      $display("FAIL kv_hold: valid=%b result=%h expected 0 / %h", output_valid, result, PT_A);
    end
  endtask

  task automatic test_back_to_back();
    int          first;
    int          n;
    logic [63:0] res;
    do_start(CT_Z, 768'h0);
    watch(17, first, n, res);
    checks++;
    if (first !== 17 || res !== 64'h0) begin
      errors++;
      $display("FAIL b2b_zero: latency=%0d result=%h expected 17 / 0", first, res);
    end
    do_start(CT_A, key_sched(KEY_A));
    watch(17, first, n, res);
    checks++;
    if (first !== 17 || n !== 1 || res !== PT_A) begin
      errors++;
      $display("FAIL b2b_second: latency=%0d pulses=%0d result=%h expected 17 / 1 / %h", first, n, res, PT_A);
    end
  endtask

  task automatic test_start_ignored();
    int           first;
    int           n;
    logic [63:0]  res;
    logic [63:0]  ct;
    logic [767:0] ks;
    logic [63:0]  exp;
    ct  = {$urandom(), $urandom()};
    ks  = rand_keys();
    exp = des_model(ct, ks, 1'b0);
    do_start(ct, ks);
    repeat (4) tick();
    ciphertext = {$urandom(), $urandom()};
    round_keys = rand_keys();
    start      = 1'b1;
    tick();
    start      = 1'b0;
    watch(30, first, n, res);
    checks++;
    if (first !== 12 || n !== 1) begin
      errors++;
      $display("FAIL ignore_pulses: first=%0d pulses=%0d expected 12 / 1", first, n);
    end
    checks++;
    if (res !== exp) begin
      errors++;
      $display("FAIL ignore_result: got %h expected %h", res, exp);
    end
  endtask

  task automatic test_input_change();
    int           first;
    int           n;
    logic [63:0]  res;
    logic [63:0]  ct;
    logic [767:0] ks;
    logic [63:0]  exp;
    for (int it = 0; it < 5; it++) begin
      ct  = {$urandom(), $urandom()};
      ks  = rand_keys();
      exp = des_model(ct, ks, 1'b0);
      do_start(ct, ks);
      tick();
      ciphertext = {$urandom(), $urandom()};
      round_keys = rand_keys();
      watch(16, first, n, res);
      checks++;
      if (first !== 16 || res !== exp) begin
        errors++;
        $display("FAIL input_change_%0d: latency=%0d result=%h expected 16 / %h", it, first, res, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    int           first;
    int           n;
    logic [63:0]  res;
    logic [63:0]  ct;
    logic [767:0] ks;
    logic [63:0]  exp;
    do_start({$urandom(), $urandom()}, rand_keys());
    repeat (8) tick();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, output_valid} !== 2'b00 || result !== 64'h0) begin
      errors++;
      $display("FAIL rst_mid_async: busy/valid=%b result=%h expected 00 / 0", {busy, output_valid}, result);
    end
    tick();
    tick();
    rst = 1'b0;
    watch(25, first, n, res);
    checks++;
    if (n !== 0) begin
      errors++;
      $display("FAIL rst_mid_no_valid: pulses=%0d expected 0", n);
    end
    ct  = {$urandom(), $urandom()};
    ks  = rand_keys();
    exp = des_model(ct, ks, 1'b0);
    do_start(ct, ks);
    watch(17, first, n, res);
    checks++;
    if (first !== 17 || res !== exp) begin
      errors++;
      $display("FAIL rst_mid_recover: latency=%0d result=%h expected 17 / %h", first, res, exp);
    end
  endtask

`ifdef DES_DEC_ENCRYPT_MODE_EN
  task automatic test_encrypt_mode();
    int           first;
    int           n;
    logic [63:0]  res;
    logic [63:0]  ct;
    logic [767:0] ks;
    encrypt = 1'b1;
    do_start(PT_A, key_sched(KEY_A));
    encrypt = 1'b0;
    watch(17, first, n, res);
    checks++;
    if (first !== 17 || res !== CT_A) begin
      errors++;
      $display("FAIL enc_known: latency=%0d result=%h expected 17 / %h", first, res, CT_A);
    end
    do_start(res, key_sched(KEY_A));
    watch(17, first, n, res);
    checks++;
    if (first !== 17 || res !== PT_A) begin
      errors++;
      $display("FAIL enc_roundtrip: latency=%0d result=%h expected 17 / %h", first, res, PT_A);
    end
    ct = {$urandom(), $urandom()};
    ks = rand_keys();
    encrypt = 1'b1;
    do_start(ct, ks);
    encrypt = 1'b0;
    watch(17, first, n, res);
    checks++;
    if (res !== des_model(ct, ks, 1'b1)) begin
      errors++;
      $display("FAIL enc_random: got %h expected %h", res, des_model(ct, ks, 1'b1));
    end
  endtask
`endif

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    start      = 1'b0;
    ciphertext = 64'h0;
    round_keys = 768'h0;
`ifdef DES_DEC_ENCRYPT_MODE_EN
    encrypt    = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    tick();
    test_known_vector();
    test_back_to_back();
    test_start_ignored();
    test_input_change();
    test_reset_mid();
`ifdef DES_DEC_ENCRYPT_MODE_EN
    test_encrypt_mode();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
